fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Decoupling instruction queue between the Fetch stage and the Decode stage.
- Captures {pc, instruction} pairs from Fetch through a valid/ready handshake and holds up to DEPTH entries.
- Presents the oldest entry to Decode, together with pc+4.
- Absorbs Decode stalls and discards all wrong-path instructions on a flush request from branch/jump resolution.

Parameters:
- DEPTH, 4: number of entries. Power of two, minimum 2.
- NOP_INST, 32'h00000013: value driven on out_instruction when no entry is presented (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  Fetch has a valid instruction
- in_ready  output  1  queue accepts an entry this cycle
- in_instruction  input  32  fetched instruction
- in_pc  input  32  program counter of in_instruction
- flush  input  1  discard all queued and incoming entries
- out_valid  output  1  head entry presented to Decode
- out_ready  input  1  Decode consumes the head entry this cycle
- out_instruction  output  32  head instruction
- out_pc  output  32  head program counter
- out_pc_plus4  output  32  out_pc + 4
- count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Clocking and reset:
  - Single clock domain, clk.
  - Reset is synchronous, active-low, sampled on the rising edge of clk.
- While rst_n = 0:
  - in_ready = 0.
  - At the next edge: write pointer, read pointer and count clear to 0.
  - Outputs after reset: out_valid = 0, out_instruction = NOP_INST, out_pc = 0, out_pc_plus4 = 4, count = 0.
  - Storage array contents are don't-care.
- Reset mid-operation drops all entries with no partial state. The first push after rst_n rises is stored at index 0.
- Handshake definitions:
  - push = in_valid && in_ready && !flush.
  - pop = out_valid && out_ready.
- in_ready:
  - in_ready = rst_n && (count != DEPTH).
  - When full, no same-cycle push-through is allowed, even if a pop occurs.
- out_valid:
  - out_valid = (count != 0) && !flush. A flush suppresses presentation in the same cycle.
- Output data:
  - When out_valid = 1, outputs show entry[rd_ptr], a combinational read of the register array.
  - Otherwise out_instruction = NOP_INST and out_pc = 0.
  - out_pc_plus4 = out_pc + 4, 32-bit modulo (0xFFFFFFFC -> 0x00000000).
- Latency:
  - An entry pushed at edge N is presented from cycle N+1.
  - Throughput is one entry per cycle, with simultaneous push and pop allowed.
- Pointers:
  - $clog2(DEPTH) bits each; wrap naturally from DEPTH-1 to 0.
  - count is tracked separately to distinguish full from empty.
- Occupancy update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop: count unchanged; both pointers advance.
- Boundary conditions:
  - Empty: pop is impossible since out_valid = 0. in_valid is accepted.
  - Full: in_ready = 0. A pop frees one slot, visible as in_ready = 1 in the next cycle.
- Flush (synchronous, highest priority after reset):
  - At the edge: count = 0 and rd_ptr = wr_ptr = 0.
  - Any in_valid that cycle is dropped.
  - No pop is recorded, since out_valid = 0 that cycle.
- Ordering: strictly FIFO; entries never reordered or duplicated.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined (bypass path):
  - When count == 0 and in_valid && !flush && rst_n, out_valid = 1 in the same cycle.
  - out_instruction, out_pc and out_pc_plus4 come directly from in_instruction / in_pc.
  - If out_ready = 1 that cycle, the entry is consumed and not written: pointers and count stay unchanged.
  - If out_ready = 0, the entry is written normally (push) and presented from the array thereafter.
  - Zero-cycle latency when empty.
- Undefined: no bypass; minimum latency 1 cycle as above.
- All other rules are identical in both builds.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with in_valid = 1 -> in_ready = 0; after release count = 0, out_valid = 0, out_instruction = 0x00000013, out_pc_plus4 = 0x4.
- Streaming: push pc 0x0,0x4,0x8 with instructions 0x00500093,0x00A00113,0x002081B3 and out_ready = 1 -> same order out one cycle after each push (zero with bypass); count never exceeds 1; out_pc_plus4 = 0x4,0x8,0xC.
- Full/stall: out_ready = 0, push 5 entries (DEPTH = 4) -> in_ready = 0 after the 4th, count = 4, 5th not accepted; raise out_ready -> pc 0x0 popped, in_ready = 1 next cycle, 5th accepted, order preserved.
- Wrap: 10 push/pop cycles at steady count = 2 -> pointers wrap past 3; outputs match a reference FIFO model exactly.
- Flush: count = 3, assert flush with in_valid = 1 (pc 0x40) -> out_valid = 0 that cycle; next cycle count = 0; pc 0x40 never appears; next push pc 0x80 presented first.
- Edge wrap: push pc 0xFFFFFFFC -> out_pc_plus4 = 0x00000000.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch-to-Decode instruction queue: DEPTH-entry FIFO of {pc, instruction} pairs with flush.
// Define FETCH_QUEUE_BYPASS_EN for a zero-latency path from Fetch to Decode while the queue is empty.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instruction,
  input  logic [31:0]                in_pc,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instruction,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_pc_plus4,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   occ;

  logic empty;
  logic full;
  logic push;
  logic bypass;
  logic bypass_take;
  logic array_valid;
  logic pop_arr;
  logic wr_en;

  assign empty    = (occ == '0);
  assign full     = (occ == CW'(DEPTH));
  assign in_ready = rst_n && !full;
  assign push     = in_valid && in_ready && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty && in_valid && !flush && rst_n;
`else
  assign bypass = 1'b0;
`endif

  // A flush hides the head in the same cycle, so no pop can be recorded alongside it.
  assign array_valid = !empty && !flush;
  assign out_valid   = array_valid || bypass;
  assign pop_arr     = array_valid && out_ready;
  assign bypass_take = bypass && out_ready;
  assign wr_en       = push && !bypass_take;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    out_instruction = NOP_INST;
    out_pc          = '0;
    if (array_valid) begin
      out_instruction = mem[rd_ptr].inst;
      out_pc          = mem[rd_ptr].pc;
    end else if (bypass) begin
      out_instruction = in_instruction;
      out_pc          = in_pc;
    end
  end

  assign out_pc_plus4 = out_pc + 32'd4;
  assign count        = occ;

  // NOTE: the storage array is deliberately not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr].pc   <= in_pc;
      mem[wr_ptr].inst <= in_instruction;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en)   wr_ptr <= wr_ptr + PW'(1);
      if (pop_arr) rd_ptr <= rd_ptr + PW'(1);
      unique case ({wr_en, pop_arr})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed steps then random traffic against a queue-based model.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instruction;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [2:0]  count;

  fetch_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instruction  (in_instruction),
    .in_pc           (in_pc),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .out_pc_plus4    (out_pc_plus4),
    .count           (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t model_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  bit     known   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then advance the model at the edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic ordy, input logic fl, input logic rs);
    logic   exp_ready;
    logic   exp_valid;
    logic   bypass;
    logic   acc;
    logic   cons;
    entry_t head;
    entry_t e;
    rst_n = rs; in_valid = v; in_pc = pc; in_instruction = inst; out_ready = ordy; flush = fl;
    #1;
    exp_ready = rs && (model_q.size() < DEPTH);
    bypass    = BYP && (model_q.size() == 0) && v && !fl && rs;
    exp_valid = !fl && ((model_q.size() > 0) || bypass);
    head.pc   = 32'h0;
    head.inst = NOP;
    if (exp_valid) begin
      if (model_q.size() > 0) head = model_q[0];
      else begin head.pc = pc; head.inst = inst; end
    end
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    if (known) begin
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      check("out_instruction", out_instruction, head.inst);
      check("out_pc", out_pc, head.pc);
      check("out_pc_plus4", out_pc_plus4, head.pc + 32'd4);
      check("count", 32'(count), 32'(model_q.size()));
    end
    @(posedge clk);
    if (!rs || fl) begin
      model_q.delete();
    end else begin
      acc  = v && exp_ready;
      cons = exp_valid && ordy;
      if (!(bypass && cons)) begin
        if (cons) void'(model_q.pop_front());
        if (acc) begin e.pc = pc; e.inst = inst; model_q.push_back(e); end
      end
    end
    if (!rs) known = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, ordy, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_instruction = '0; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);

    // Reset held two cycles with Fetch offering an instruction.
    step(1'b1, 32'h0, 32'h00500093, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0, 32'h00500093, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1);

    // Streaming three instructions with Decode always ready.
    step(1'b1, 32'h0, 32'h00500093, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h4, 32'h00A00113, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h8, 32'h002081B3, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 2);

    // Fill to full with Decode stalled; fifth offer is refused until a pop frees a slot.
    for (int i = 0; i < 5; i++) step(1'b1, 32'h100 + 32'(4 * i), 32'hA000 + 32'(i), 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h110, 32'hA004, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h110, 32'hA004, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 5);

    // Steady occupancy of two for ten push/pop cycles so both pointers wrap.
    step(1'b1, 32'h200, 32'hB000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h204, 32'hB001, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 32'h208 + 32'(4 * i), 32'hB002 + 32'(i), 1'b1, 1'b0, 1'b1);
    idle(1'b1, 3);

    // Flush with three queued and a wrong-path fetch; the next fetch comes out first.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h30 + 32'(4 * i), 32'hC000 + 32'(i), 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h40, 32'hC0DE, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h80, 32'hC080, 1'b0, 1'b0, 1'b1);
    idle(1'b1, 2);

    // pc + 4 wraps modulo 2^32.
    step(1'b1, 32'hFFFFFFFC, 32'hD000, 1'b0, 1'b0, 1'b1);
    idle(1'b1, 2);

    // Reset mid-operation drops queued entries.
    step(1'b1, 32'h300, 32'hE000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h304, 32'hE001, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h308, 32'hE002, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h30C, 32'hE003, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 2);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, $urandom & 32'hFFFFFFFC, $urandom,
           ($urandom % 3) != 0, ($urandom % 16) == 0, ($urandom % 64) != 0);
    end
    idle(1'b1, DEPTH + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
